// File: rtl/reflet_ram16_copier_if.sv
// RAM-side bus of the block-copy engine: the copier masters enable/addr/data/write_en
// and the RAM answers with its registered read data.
interface reflet_ram16_copier_if #(
    parameter int ADDR_SIZE = 9
);
    logic                 mem_enable;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [15:0]          mem_data_out;
    logic                 mem_write_en;
    logic [15:0]          mem_data_in;

    // Handshake: a read is requested when enable=1/write_en=0 and its data is valid
    // the following cycle; a write commits on the edge where enable and write_en are both 1.
    modport master (
        output mem_enable,
        output mem_addr,
        output mem_data_out,
        output mem_write_en,
        input  mem_data_in
    );

    modport slave (
        input  mem_enable,
        input  mem_addr,
        input  mem_data_out,
        input  mem_write_en,
        output mem_data_in
    );
endinterface

// File: rtl/reflet_ram16_copier.sv
// Block-copy engine: copies len bytes from src to dst in forward 16-bit word transfers,
// finishing odd lengths with a read-modify-write that keeps the byte after the range.
module reflet_ram16_copier #(
    parameter int addrSize = 9,
    parameter int lenSize  = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [addrSize-1:0] src,
    input  logic [addrSize-1:0] dst,
    input  logic [lenSize-1:0]  len,
    output logic                busy,
    output logic                done,
    output logic [2:0]          o_dbg_state,
    reflet_ram16_copier_if.master mem
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READ      = 3'd1,
        S_WAIT      = 3'd2,
        S_WRITE     = 3'd3,
        S_TAIL_RD   = 3'd4,
        S_TAIL_WAIT = 3'd5,
        S_TAIL_WR   = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic                r_en;
    logic                r_we;
    logic [addrSize-1:0] r_addr;
    logic [15:0]         r_wdata;
    logic [addrSize-1:0] r_cur_src;
    logic [addrSize-1:0] r_cur_dst;
    logic [lenSize-1:0]  r_remaining;
    logic [15:0]         r_buf;

    logic [addrSize-1:0] w_src_next;
    logic [addrSize-1:0] w_dst_next;
    logic [lenSize-1:0]  w_rem_next;
    logic [15:0]         w_tail_word;

    assign w_src_next  = r_cur_src + addrSize'(2);
    assign w_dst_next  = r_cur_dst + addrSize'(2);
    assign w_rem_next  = r_remaining - lenSize'(2);
    assign w_tail_word = {mem.mem_data_in[15:8], r_buf[7:0]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_en        <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cur_src   <= '0;
            r_cur_dst   <= '0;
            r_remaining <= '0;
            r_buf       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            r_cur_src   <= src;
                            r_cur_dst   <= dst;
                            r_remaining <= len;
                            r_en        <= 1'b1;
                            r_we        <= 1'b0;
                            r_addr      <= src;
                            r_busy      <= 1'b1;
                            r_state     <= S_READ;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_READ: begin
                    r_en    <= 1'b0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_buf  <= mem.mem_data_in;
                    r_en   <= 1'b1;
                    r_addr <= r_cur_dst;
                    if (r_remaining >= lenSize'(2)) begin
                        r_we    <= 1'b1;
                        r_wdata <= mem.mem_data_in;
                        r_state <= S_WRITE;
                    end else begin
                        r_we    <= 1'b0;
                        r_state <= S_TAIL_RD;
                    end
                end
                S_WRITE: begin
                    r_cur_src   <= w_src_next;
                    r_cur_dst   <= w_dst_next;
                    r_remaining <= w_rem_next;
                    r_we        <= 1'b0;
                    if (w_rem_next == '0) begin
                        r_en    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_en    <= 1'b1;
                        r_addr  <= w_src_next;
                        r_state <= S_READ;
                    end
                end
                S_TAIL_RD: begin
                    r_en    <= 1'b0;
                    r_state <= S_TAIL_WAIT;
                end
                S_TAIL_WAIT: begin
                    // Keep the destination's upper byte, replace only the last copied byte.
                    r_buf   <= w_tail_word;
                    r_wdata <= w_tail_word;
                    r_en    <= 1'b1;
                    r_we    <= 1'b1;
                    r_state <= S_TAIL_WR;
                end
                S_TAIL_WR: begin
                    r_en        <= 1'b0;
                    r_we        <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_remaining <= '0;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy             = r_busy;
    assign done             = r_done;
    assign o_dbg_state      = r_state;
    assign mem.mem_enable   = r_en;
    assign mem.mem_addr     = r_addr;
    assign mem.mem_data_out = r_wdata;
    // Masked by reset so the edge that aborts a copy can never commit a pending write.
    assign mem.mem_write_en = r_we & reset;

endmodule

// File: tb/tb_reflet_ram16_copier.sv
// Directed bench for reflet_ram16_copier: behavioural RAM, write scoreboard fed by a
// forward-copy reference model, and latency/pulse/reset checks.
module tb_reflet_ram16_copier;

    logic       clk;
    logic       reset;
    logic       start;
    logic [8:0] src;
    logic [8:0] dst;
    logic [8:0] len;
    logic       busy;
    logic       done;
    logic [2:0] dbg_state;

    reflet_ram16_copier_if #(.ADDR_SIZE(9)) bus ();

    reflet_ram16_copier #(.addrSize(9), .lenSize(9)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .src         (src),
        .dst         (dst),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .o_dbg_state (dbg_state),
        .mem         (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: {addr, data} of every write the copier is expected to issue, in order.
    logic [24:0] exp_q[$];

    logic [7:0]  mem     [0:511];
    logic [7:0]  ref_mem [0:511];
    logic [15:0] r_rdata;
    int          n_writes = 0;
    int          n_enables = 0;

    assign bus.mem_data_in = r_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural RAM: little-endian word access at any byte address, registered read.
    always @(posedge clk) begin
        logic [8:0]  a1;
        logic [24:0] e;
        a1 = bus.mem_addr + 9'd1;
        if (bus.mem_enable) n_enables++;
        if (bus.mem_enable && bus.mem_write_en) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {7'd0, bus.mem_addr, bus.mem_data_out}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(bus.mem_addr), 32'(e[24:16]));
                check("write_data", 32'(bus.mem_data_out), 32'(e[15:0]));
            end
            mem[bus.mem_addr] = bus.mem_data_out[7:0];
            mem[a1]           = bus.mem_data_out[15:8];
        end else if (bus.mem_enable) begin
            r_rdata <= {mem[a1], mem[bus.mem_addr]};
        end
    end

    // Driver tasks
    task automatic poke(input logic [8:0] a, input logic [7:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    task automatic push_write(input logic [8:0] a, input logic [15:0] w);
        exp_q.push_back({a, w});
        ref_mem[a]         = w[7:0];
        ref_mem[a + 9'd1]  = w[15:8];
    endtask

    // Reference: forward word-by-word copy, odd tail merges the destination's next byte.
    task automatic model_copy(input logic [8:0] s, input logic [8:0] d, input int l);
        logic [8:0]  cs;
        logic [8:0]  cd;
        logic [15:0] w;
        int          rem;
        cs  = s;
        cd  = d;
        rem = l;
        while (rem > 0) begin
            w = {ref_mem[cs + 9'd1], ref_mem[cs]};
            if (rem >= 2) begin
                push_write(cd, w);
                cs  = cs + 9'd2;
                cd  = cd + 9'd2;
                rem = rem - 2;
            end else begin
                push_write(cd, {ref_mem[cd + 9'd1], w[7:0]});
                rem = 0;
            end
        end
    endtask

    task automatic run_copy(input logic [8:0] s, input logic [8:0] d, input int l, input bit repulse);
        int exp_n;
        int cyc;
        int first;
        int dones;
        int w0;
        exp_n = 3 * (l / 2) + 5 * (l % 2) + 1;
        w0    = n_writes;
        model_copy(s, d, l);
        src   = s;
        dst   = d;
        len   = 9'(l);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        first = 0;
        dones = 0;
        check("busy_cycle1", 32'(busy), 32'(l != 0));
        while (cyc < 400) begin
            if (done === 1'b1) begin
                dones++;
                if (first == 0) first = cyc;
            end
            if (first != 0 && cyc >= first + 3) break;
            start = (repulse && cyc == 2);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("done_latency", 32'(first), 32'(exp_n));
        check("done_pulses", 32'(dones), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("write_count", 32'(n_writes - w0), 32'((l + 1) / 2));
    endtask

    task automatic check_byte(input string tag, input logic [8:0] a, input logic [7:0] v);
        check(tag, 32'(mem[a]), 32'(v));
    endtask

    initial begin
        int e0;
        int w0;
        reset = 1'b0;
        start = 1'b0;
        src   = '0;
        dst   = '0;
        len   = '0;
        r_rdata = '0;
        for (int i = 0; i < 512; i++) poke(9'(i), 8'($urandom_range(0, 255)));
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_enable", 32'(bus.mem_enable), 32'd0);
        check("rst_write_en", 32'(bus.mem_write_en), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_data_out", 32'(bus.mem_data_out), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Aligned copy
        poke(9'h000, 8'h11); poke(9'h001, 8'h22); poke(9'h002, 8'h33); poke(9'h003, 8'h44);
        run_copy(9'h000, 9'h040, 4, 1'b0);
        check_byte("aligned_40", 9'h040, 8'h11);
        check_byte("aligned_41", 9'h041, 8'h22);
        check_byte("aligned_42", 9'h042, 8'h33);
        check_byte("aligned_43", 9'h043, 8'h44);

        // Odd length keeps the following destination byte
        poke(9'h010, 8'hA1); poke(9'h011, 8'hB2); poke(9'h012, 8'hC3); poke(9'h083, 8'hEE);
        run_copy(9'h010, 9'h080, 3, 1'b0);
        check_byte("odd_80", 9'h080, 8'hA1);
        check_byte("odd_81", 9'h081, 8'hB2);
        check_byte("odd_82", 9'h082, 8'hC3);
        check_byte("odd_83_kept", 9'h083, 8'hEE);

        // Unaligned source and destination
        for (int i = 0; i < 6; i++) poke(9'h005 + 9'(i), 8'(i + 1));
        poke(9'h021, 8'h77); poke(9'h028, 8'h88);
        run_copy(9'h005, 9'h022, 6, 1'b0);
        for (int i = 0; i < 6; i++) check_byte("unaligned_byte", 9'h022 + 9'(i), 8'(i + 1));
        check_byte("unaligned_21_kept", 9'h021, 8'h77);
        check_byte("unaligned_28_kept", 9'h028, 8'h88);

        // Zero length: no memory traffic
        e0 = n_enables;
        run_copy(9'h000, 9'h030, 0, 1'b0);
        check("len0_no_enable", 32'(n_enables - e0), 32'd0);

        // Start while busy is ignored
        run_copy(9'h060, 9'h0A1, 5, 1'b1);

        // Address wrap
        poke(9'h1FE, 8'hC1); poke(9'h1FF, 8'hC2); poke(9'h000, 8'hC3); poke(9'h001, 8'hC4);
        run_copy(9'h1FE, 9'h010, 4, 1'b0);
        check_byte("wrap_10", 9'h010, 8'hC1);
        check_byte("wrap_11", 9'h011, 8'hC2);
        check_byte("wrap_12", 9'h012, 8'hC3);
        check_byte("wrap_13", 9'h013, 8'hC4);

        // Reset during the second WRITE of a len=8 copy
        for (int i = 0; i < 8; i++) poke(9'h100 + 9'(i), 8'(8'h50 + 8'(i)));
        poke(9'h182, 8'h5A);
        w0 = n_writes;
        push_write(9'h180, {ref_mem[9'h101], ref_mem[9'h100]});
        src   = 9'h100;
        dst   = 9'h180;
        len   = 9'd8;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("abort_in_write", 32'(dbg_state), 32'd3);
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_write_en", 32'(bus.mem_write_en), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("abort_no_done", 32'(done), 32'd0);
        check("abort_write_count", 32'(n_writes - w0), 32'd1);
        check("abort_queue", 32'(exp_q.size()), 32'd0);
        check_byte("abort_182_kept", 9'h182, 8'h5A);
        ref_mem[9'h182] = mem[9'h182];
        ref_mem[9'h183] = mem[9'h183];

        // Fresh copy after reset
        run_copy(9'h100, 9'h180, 8, 1'b0);
        for (int i = 0; i < 8; i++) check_byte("post_reset_byte", 9'h180 + 9'(i), 8'(8'h50 + 8'(i)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
